// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Selects the next PC in the pre-IF cycle and issues a synchronous inst-SRAM request.
// Holds the fetched instruction in the IF register until decode accepts it.
// Optional feature macro: IF_ADDR_EXC_EN. When defined, a misaligned fetch
// address raises fs_adel, the instruction is replaced with a nop, and
// fs_to_ds_bus grows to 65 bits.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic [33:0] br_bus,
    output logic        fs_to_ds_valid,
`ifdef IF_ADDR_EXC_EN
    output logic [64:0] fs_to_ds_bus,
`else
    output logic [63:0] fs_to_ds_bus,
`endif
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    logic        br_stall;
    logic        br_token;
    logic [31:0] br_target;
    logic        br_taken;

    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic        to_fs_valid;
    logic        fs_advance;
    logic [31:0] nextpc;

    logic        pend_valid;
    logic [31:0] pend_pc;

    logic        ibuf_valid;
    logic [31:0] ibuf;
    logic [31:0] raw_inst;
    logic [31:0] fs_inst;

    assign br_stall  = br_bus[33];
    assign br_token  = br_bus[32];
    assign br_target = br_bus[31:0];
    assign br_taken  = br_token && !br_stall;

    assign fs_ready_go    = 1'b1;
    assign fs_allowin     = !fs_valid || ds_allowin;
    assign fs_to_ds_valid = fs_valid && fs_ready_go;

    // The IF slot advances whenever pre-IF is valid and IF can take a new pc;
    // without the alignment check this is exactly the SRAM request.
    assign to_fs_valid = !reset && !br_stall;
    assign fs_advance  = to_fs_valid && fs_allowin;

    // Next-PC select: reset vector, then live branch, then a latched branch, then sequential.
    always_comb begin
        nextpc = fs_pc + 32'd4;
        if (reset) begin
            nextpc = RESET_PC;
        end else if (br_taken) begin
            nextpc = br_target;
        end else if (pend_valid) begin
            nextpc = pend_pc;
        end
    end

    assign inst_sram_addr  = nextpc;
    assign inst_sram_wen   = 4'h0;
    assign inst_sram_wdata = 32'h0;

    // The SRAM only holds its data for one cycle, so a stalled instruction reads from the buffer.
    assign raw_inst = ibuf_valid ? ibuf : inst_sram_rdata;

`ifdef IF_ADDR_EXC_EN
    logic fs_adel;
    logic addr_misaligned;

    assign addr_misaligned = nextpc[1:0] != 2'b00;
    assign inst_sram_en    = fs_advance && !addr_misaligned;
    assign fs_inst         = fs_adel ? 32'h0 : raw_inst;
    assign fs_to_ds_bus    = {fs_adel, fs_inst, fs_pc};

    // Remember whether the instruction now in IF came from a misaligned address.
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_adel <= 1'b0;
        end else if (fs_advance) begin
            fs_adel <= addr_misaligned;
        end
    end
`else
    assign inst_sram_en = fs_advance;
    assign fs_inst      = raw_inst;
    assign fs_to_ds_bus = {fs_inst, fs_pc};
`endif

    // IF register: take the new pc on advance; drain to a bubble when nothing is fetched.
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid <= 1'b0;
            fs_pc    <= RESET_PC - 32'd4;
        end else if (fs_advance) begin
            fs_valid <= 1'b1;
            fs_pc    <= nextpc;
        end else if (fs_allowin) begin
            fs_valid <= 1'b0;
        end
    end

    // Latch a taken branch target that could not be fetched this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_pc    <= 32'h0;
        end else if (br_taken && !fs_advance) begin
            pend_valid <= 1'b1;
            pend_pc    <= br_target;
        end else if (fs_advance) begin
            pend_valid <= 1'b0;
        end
    end

    // Capture SRAM data on the first stalled cycle; release it once decode takes the instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            ibuf_valid <= 1'b0;
            ibuf       <= 32'h0;
        end else if (fs_valid && !ds_allowin && !ibuf_valid) begin
            ibuf_valid <= 1'b1;
            ibuf       <= inst_sram_rdata;
        end else if (fs_valid && ds_allowin) begin
            ibuf_valid <= 1'b0;
        end
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: pre-IF next-PC selection, synchronous inst-SRAM request, IF pipeline register.
- Sits upstream of the decode stage: produces fs_to_ds_valid/fs_to_ds_bus and consumes ds_allowin plus br_bus {br_stall, br_token, br_target}.
- Branches resolve in decode with one architectural delay slot. The instruction held in IF when a branch is in decode is the delay slot.

Parameters:
RESET_PC, 32'hbfc00000, address of the first fetch after reset.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
ds_allowin  input  1  decode can accept an instruction this cycle
br_bus  input  34  {br_stall[33], br_token[32], br_target[31:0]} from decode
fs_to_ds_valid  output  1  IF holds a valid instruction for decode
fs_to_ds_bus  output  64  {fs_inst[63:32], fs_pc[31:0]}
inst_sram_en  output  1  fetch request; SRAM returns rdata the next cycle
inst_sram_wen  output  4  tied 4'h0
inst_sram_addr  output  32  fetch address (nextpc)
inst_sram_wdata  output  32  tied 32'h0
inst_sram_rdata  input  32  instruction data, valid the cycle after an accepted request

Behaviour:
- Handshake:
  - fs_ready_go = 1.
  - fs_allowin = !fs_valid || ds_allowin.
  - fs_to_ds_valid = fs_valid.
- Pre-IF:
  - to_fs_valid = !reset && !br_stall.
  - inst_sram_en = to_fs_valid && fs_allowin. Fetch is accepted only when inst_sram_en = 1.
- nextpc priority:
  1. br_target, if br_token && !br_stall.
  2. Else pend_pc, if pend_valid.
  3. Else fs_pc + 4 (32-bit, wraps 32'hfffffffc -> 32'h0).
- inst_sram_addr = nextpc.
- On an accepted fetch:
  - fs_pc <= nextpc.
  - fs_valid <= 1.
- When fs_allowin && !inst_sram_en: fs_valid <= 0, which creates a bubble.
- Branch pending:
  - If br_token && !br_stall && !inst_sram_en: pend_valid <= 1, pend_pc <= br_target.
  - An accepted fetch clears pend_valid.
  - A live br_token in the same cycle overrides pend_pc.
- br_stall = 1 means the target is unreliable.
  - Issue no fetch and do not latch the pending target.
  - IF contents are held, or drained if ds_allowin = 1.
- Instruction buffer:
  - SRAM output is only guaranteed in the single cycle after the request.
  - If fs_valid && !ds_allowin && !ibuf_valid: ibuf <= inst_sram_rdata, ibuf_valid <= 1.
  - ibuf_valid clears when fs_valid && ds_allowin.
  - fs_inst = ibuf_valid ? ibuf : inst_sram_rdata.
- Latency: first accepted request is at cycle N. fs_to_ds_valid is asserted with that instruction at N+1. Steady throughput is 1 instruction/cycle.
- Reset values:
  - fs_valid = 0, fs_pc = RESET_PC - 4, pend_valid = 0, ibuf_valid = 0, ibuf = 0.
  - Outputs during reset: fs_to_ds_valid = 0, inst_sram_en = 0, inst_sram_addr = RESET_PC.
- The first cycle after reset deasserts fetches RESET_PC.
- Reset asserted mid-operation discards IF, pending and buffer state on the next edge.
- Simultaneous events:
  - Branch taken while decode stalls: no fetch is issued, the target is latched, and the delay slot stays in IF.
  - ds_allowin and fetch acceptance in the same cycle: the old instruction transfers to decode and the new pc enters IF.

Optional Feature:
IF_ADDR_EXC_EN:
- Defined: nextpc[1:0] != 0 still advances the pipeline, but inst_sram_en is forced to 0 for that fetch.
  - IF carries fs_adel = 1 and fs_inst = 32'h0 (nop).
  - fs_to_ds_bus widens to 65 bits with fs_adel at bit 64.
- Undefined: no alignment check, the bus is 64 bits, and the low address bits are passed to SRAM unchanged.

Test Plan:
1. Reset 3 cycles, release, ds_allowin = 1, rdata = 32'h24010001 -> cycle 0: en = 1, addr = 32'hbfc00000; cycle 1: fs_to_ds_valid = 1, bus = {32'h24010001, 32'hbfc00000}, addr = 32'hbfc00004.
2. Stream with ds_allowin = 0 for 3 cycles while rdata changes to 32'hdeadbeef after the first cycle -> en = 0, addr frozen, bus keeps the original inst (from ibuf), pc unchanged; after release, the next pc is fs_pc + 4.
3. Branch in decode with br_token = 1, br_target = 32'hbfc00100, delay slot 32'hbfc00008 in IF -> addr = 32'hbfc00100; the next IF pc is 32'hbfc00100, not 32'hbfc0000c.
4. br_token = 1 with br_stall = 1 for 2 cycles, then br_stall = 0 with target 32'hbfc00200 -> en = 0 for 2 cycles, no pc change, then a fetch to 32'hbfc00200.
5. br_token while ds_allowin = 0 (IF full), then token drops and ds_allowin = 1 -> pend latch holds the target, and the next fetch goes to the latched target.
6. Reset asserted mid-stream with pend_valid and ibuf_valid set -> next cycle fs_to_ds_valid = 0; after release the fetch is at 32'hbfc00000.
